// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared definitions for the intersection scheduler: phase codes, direction
//   codes, the lamp bundle with its decode function, and default durations.
// -----------------------------------------------------------------------------
package traffic_pkg;

    // Phase codes are a full 3-bit code, so no illegal phase value exists.
    typedef enum logic [2:0] {
        PH_NS_GREEN  = 3'd0,
        PH_NS_YELLOW = 3'd1,
        PH_ALL_RED_A = 3'd2,
        PH_EW_GREEN  = 3'd3,
        PH_EW_YELLOW = 3'd4,
        PH_ALL_RED_B = 3'd5,
        PH_PED_WALK  = 3'd6,
        PH_EMG_HOLD  = 3'd7
    } phase_t;

    // Green that follows a pedestrian walk.
    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_t;

    typedef struct packed {
        logic ns_green;
        logic ns_yellow;
        logic ns_red;
        logic ew_green;
        logic ew_yellow;
        logic ew_red;
    } lamps_t;

    localparam int DEF_CW         = 5;
    localparam int DEF_T_GREEN_NS = 18;
    localparam int DEF_T_GREEN_EW = 15;
    localparam int DEF_T_YELLOW   = 3;
    localparam int DEF_T_ALLRED   = 2;
    localparam int DEF_T_WALK     = 10;

    // Each approach shows red unless it is in its own green or yellow, so
    // exactly one lamp per approach is lit for every phase code.
    function automatic lamps_t lamp_decode(input phase_t ph);
        lamps_t l;
        l.ns_green  = (ph == PH_NS_GREEN);
        l.ns_yellow = (ph == PH_NS_YELLOW);
        l.ns_red    = !(l.ns_green || l.ns_yellow);
        l.ew_green  = (ph == PH_EW_GREEN);
        l.ew_yellow = (ph == PH_EW_YELLOW);
        l.ew_red    = !(l.ew_green || l.ew_yellow);
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   Down-counter holding the ticks left in the current phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this clk (takes priority over tick)
//   load_val   : duration of the phase being entered
//   tick       : timebase enable; decrements remaining while it is non-zero
//   remaining  : registered ticks-left value
//   expire     : tick & remaining==1, i.e. this tick ends the phase
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int            CW      = 5,
    parameter logic [CW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          tick,
    output logic [CW-1:0] remaining,
    output logic          expire
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= RST_VAL;
        end else if (load) begin
            remaining <= load_val;
        end else if (tick && (remaining != '0)) begin
            remaining <= remaining - CW'(1);
        end
    end

    assign expire = tick && (remaining == CW'(1));

endmodule

// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
//   Two-approach (NS/EW) phase scheduler with all-red clearance, latched
//   pedestrian service and emergency preemption.
//   clk, rst_n        : clock, asynchronous active-low reset
//   tick              : one-clk pulse per second (timebase enable)
//   ped_req           : pedestrian button, sampled every clk
//   emg_req           : emergency preempt level
//   ns_*/ew_* lamps   : one-hot per approach, registered
//   walk              : high only in PED_WALK
//   ped_ack           : one-clk pulse on entry to PED_WALK
//   phase             : current phase code
//   remaining         : ticks left in current phase (0 in EMG_HOLD)
// -----------------------------------------------------------------------------
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int CW         = DEF_CW,
    parameter int T_GREEN_NS = DEF_T_GREEN_NS,
    parameter int T_GREEN_EW = DEF_T_GREEN_EW,
    parameter int T_YELLOW   = DEF_T_YELLOW,
    parameter int T_ALLRED   = DEF_T_ALLRED,
    parameter int T_WALK     = DEF_T_WALK
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          ped_req,
    input  logic          emg_req,
    output logic          ns_green,
    output logic          ns_yellow,
    output logic          ns_red,
    output logic          ew_green,
    output logic          ew_yellow,
    output logic          ew_red,
    output logic          walk,
    output logic          ped_ack,
    output logic [2:0]    phase,
    output logic [CW-1:0] remaining
);

    phase_t        phase_q, phase_d;
    dir_t          next_dir_q, next_dir_d;
    logic          ped_pending_q;
    lamps_t        lamps_q;
    logic          phase_change;
    logic          entering_walk;
    logic          timer_tick;
    logic          t_expire;
    logic [CW-1:0] t_remaining;

    function automatic logic [CW-1:0] phase_dur(input phase_t ph);
        case (ph)
            PH_NS_GREEN:  return CW'(T_GREEN_NS);
            PH_NS_YELLOW: return CW'(T_YELLOW);
            PH_ALL_RED_A: return CW'(T_ALLRED);
            PH_EW_GREEN:  return CW'(T_GREEN_EW);
            PH_EW_YELLOW: return CW'(T_YELLOW);
            PH_ALL_RED_B: return CW'(T_ALLRED);
            PH_PED_WALK:  return CW'(T_WALK);
            default:      return '0;   // EMG_HOLD shows 0
        endcase
    endfunction

    // EMG_HOLD ignores the timebase; its count sits at 0.
    assign timer_tick = tick && (phase_q != PH_EMG_HOLD);

    // ---------------------------------------------------------------------
    // Next-phase logic. Emergency is checked before pedestrian service at
    // every decision point; a green yields to emergency without waiting for
    // a tick.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned and no latch is inferred.
        phase_d    = phase_q;
        next_dir_d = next_dir_q;
        case (phase_q)
            PH_NS_GREEN: begin
                if (emg_req || t_expire) phase_d = PH_NS_YELLOW;
            end
            PH_NS_YELLOW: begin
                if (t_expire) phase_d = emg_req ? PH_EMG_HOLD : PH_ALL_RED_A;
            end
            PH_ALL_RED_A: begin
                if (t_expire) begin
                    if (emg_req) begin
                        phase_d = PH_EMG_HOLD;
                    end else if (ped_pending_q) begin
                        phase_d    = PH_PED_WALK;
                        next_dir_d = DIR_EW;
                    end else begin
                        phase_d = PH_EW_GREEN;
                    end
                end
            end
            PH_EW_GREEN: begin
                if (emg_req || t_expire) phase_d = PH_EW_YELLOW;
            end
            PH_EW_YELLOW: begin
                if (t_expire) phase_d = emg_req ? PH_EMG_HOLD : PH_ALL_RED_B;
            end
            PH_ALL_RED_B: begin
                if (t_expire) begin
                    if (emg_req) begin
                        phase_d = PH_EMG_HOLD;
                    end else if (ped_pending_q) begin
                        phase_d    = PH_PED_WALK;
                        next_dir_d = DIR_NS;
                    end else begin
                        phase_d = PH_NS_GREEN;
                    end
                end
            end
            PH_PED_WALK: begin
                if (t_expire) begin
                    if (emg_req)                    phase_d = PH_EMG_HOLD;
                    else if (next_dir_q == DIR_EW)  phase_d = PH_EW_GREEN;
                    else                            phase_d = PH_NS_GREEN;
                end
            end
            PH_EMG_HOLD: begin
                if (!emg_req) phase_d = PH_ALL_RED_B;
            end
            default: phase_d = PH_ALL_RED_B;
        endcase
    end

    // No transition returns to its own phase, so a change of code is
    // exactly a phase entry and triggers the duration load.
    assign phase_change  = (phase_d != phase_q);
    assign entering_walk = (phase_d == PH_PED_WALK) && (phase_q != PH_PED_WALK);

    phase_timer #(
        .CW      (CW),
        .RST_VAL (CW'(T_ALLRED))
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (phase_change),
        .load_val  (phase_dur(phase_d)),
        .tick      (timer_tick),
        .remaining (t_remaining),
        .expire    (t_expire)
    );

    // ---------------------------------------------------------------------
    // Phase state and registered outputs. Lamps and walk are decoded from
    // the next phase so they change on the same edge as the phase code.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= PH_ALL_RED_B;
            next_dir_q    <= DIR_NS;
            ped_pending_q <= 1'b0;
            lamps_q       <= lamp_decode(PH_ALL_RED_B);
            walk          <= 1'b0;
            ped_ack       <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            next_dir_q <= next_dir_d;
            lamps_q    <= lamp_decode(phase_d);
            walk       <= (phase_d == PH_PED_WALK);
            ped_ack    <= entering_walk;
            // Clear wins: a press on the entry clk is already being served.
            if (entering_walk) begin
                ped_pending_q <= 1'b0;
            end else if (ped_req && (phase_q != PH_PED_WALK)) begin
                ped_pending_q <= 1'b1;
            end
        end
    end

    assign phase     = phase_q;
    assign remaining = t_remaining;
    assign ns_green  = lamps_q.ns_green;
    assign ns_yellow = lamps_q.ns_yellow;
    assign ns_red    = lamps_q.ns_red;
    assign ew_green  = lamps_q.ew_green;
    assign ew_yellow = lamps_q.ew_yellow;
    assign ew_red    = lamps_q.ew_red;

endmodule
